// File: rtl/core_ctrl_pkg.sv
// Shared constants for the core pipeline hazard/flush control.
// State encoding, the x0 register id and performance counter width.
package core_ctrl_pkg;

   localparam int PERF_W = 32;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_REDIRECT = 2'd2,
      ST_BAD      = 2'd3
   } hc_state_e;

   function automatic logic src_hit(
      input logic       en,
      input logic [4:0] rs,
      input logic [4:0] rd
   );
      return en && (rs == rd);
   endfunction

endpackage

// File: rtl/hazard_flush_ctrl_perf.sv
// Wrap-around event counter with synchronous clear.
// Used for the stall-cycle and redirect-event statistics.
module perf_counter
   import core_ctrl_pkg::*;
#(
   parameter int W = PERF_W
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Load-use stall and branch-redirect flush control for the 5-stage core.
// Controls are combinational from state; only state and counters are flopped.
module hazard_flush_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int LOAD_USE_BUBBLES = 1,
   parameter int FLUSH_CYCLES     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        IF_ID_Rs1,
   input  logic [4:0]        IF_ID_Rs2,
   input  logic              Use_Rs1,
   input  logic              Use_Rs2,
   input  logic              ID_EX_MemRead,
   input  logic [4:0]        ID_EX_Rd,
   input  logic              EX_Redirect,
   output logic              PC_Stall,
   output logic              IF_ID_Stall,
   output logic              IF_ID_Flush,
   output logic              ID_EX_Flush,
   output logic [1:0]        Hc_State,
   output logic [PERF_W-1:0] Stall_Count,
   output logic [PERF_W-1:0] Flush_Count
);

   localparam logic [2:0] BC_INIT = 3'(LOAD_USE_BUBBLES - 1);
   localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES - 1);

   hc_state_e  state_q, state_d;
   logic [2:0] bcnt_q, bcnt_d;
   logic [2:0] fcnt_q, fcnt_d;
   logic       lu;
   logic       redir_acc;

   assign lu = ID_EX_MemRead && (ID_EX_Rd != REG_ZERO) &&
               (src_hit(Use_Rs1, IF_ID_Rs1, ID_EX_Rd) ||
                src_hit(Use_Rs2, IF_ID_Rs2, ID_EX_Rd));

   always_comb begin
      state_d     = state_q;
      bcnt_d      = bcnt_q;
      fcnt_d      = fcnt_q;
      PC_Stall    = 1'b0;
      IF_ID_Stall = 1'b0;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
      redir_acc   = 1'b0;
      if (rst) begin
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
         state_d     = ST_RUN;
         bcnt_d      = '0;
         fcnt_d      = '0;
      end else if (EX_Redirect && (state_q != ST_BAD)) begin
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
         redir_acc   = 1'b1;
         bcnt_d      = '0;
         if (FLUSH_CYCLES > 1) begin
            state_d = ST_REDIRECT;
            fcnt_d  = FC_INIT;
         end else begin
            state_d = ST_RUN;
         end
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (lu) begin
                  PC_Stall    = 1'b1;
                  IF_ID_Stall = 1'b1;
                  ID_EX_Flush = 1'b1;
                  if (LOAD_USE_BUBBLES > 1) begin
                     state_d = ST_LU_STALL;
                     bcnt_d  = BC_INIT;
                  end
               end
            end
            // ID/EX already holds a bubble here, so lu is not re-evaluated
            ST_LU_STALL: begin
               PC_Stall    = 1'b1;
               IF_ID_Stall = 1'b1;
               ID_EX_Flush = 1'b1;
               bcnt_d      = bcnt_q - 3'd1;
               if (bcnt_q == 3'd1) state_d = ST_RUN;
            end
            ST_REDIRECT: begin
               IF_ID_Flush = 1'b1;
               fcnt_d      = fcnt_q - 3'd1;
               if (fcnt_q == 3'd1) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         bcnt_q  <= '0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign Hc_State = state_q;

   perf_counter #(.W(PERF_W)) u_stall_cnt (
      .clk     (clk),
      .clr_i   (rst),
      .en_i    (PC_Stall && !rst),
      .count_o (Stall_Count)
   );

   perf_counter #(.W(PERF_W)) u_flush_cnt (
      .clk     (clk),
      .clr_i   (rst),
      .en_i    (redir_acc),
      .count_o (Flush_Count)
   );

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl in three parameter configurations.
// Instances share stimulus; each scenario checks the relevant instance.
module tb_hazard_flush_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1, rs2, rd;
   logic       u1, u2, mr, redir;

   logic        a_pcs, a_ifs, a_iff, a_idf;
   logic [1:0]  a_st;
   logic [31:0] a_sc, a_fc;
   logic        b_pcs, b_ifs, b_iff, b_idf;
   logic [1:0]  b_st;
   logic [31:0] b_sc, b_fc;
   logic        c_pcs, c_ifs, c_iff, c_idf;
   logic [1:0]  c_st;
   logic [31:0] c_sc, c_fc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_flush_ctrl #(.LOAD_USE_BUBBLES(1), .FLUSH_CYCLES(1)) u_a (
      .clk(clk), .rst(rst), .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2),
      .Use_Rs1(u1), .Use_Rs2(u2), .ID_EX_MemRead(mr), .ID_EX_Rd(rd),
      .EX_Redirect(redir), .PC_Stall(a_pcs), .IF_ID_Stall(a_ifs),
      .IF_ID_Flush(a_iff), .ID_EX_Flush(a_idf), .Hc_State(a_st),
      .Stall_Count(a_sc), .Flush_Count(a_fc)
   );

   hazard_flush_ctrl #(.LOAD_USE_BUBBLES(2), .FLUSH_CYCLES(2)) u_b (
      .clk(clk), .rst(rst), .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2),
      .Use_Rs1(u1), .Use_Rs2(u2), .ID_EX_MemRead(mr), .ID_EX_Rd(rd),
      .EX_Redirect(redir), .PC_Stall(b_pcs), .IF_ID_Stall(b_ifs),
      .IF_ID_Flush(b_iff), .ID_EX_Flush(b_idf), .Hc_State(b_st),
      .Stall_Count(b_sc), .Flush_Count(b_fc)
   );

   hazard_flush_ctrl #(.LOAD_USE_BUBBLES(3), .FLUSH_CYCLES(2)) u_c (
      .clk(clk), .rst(rst), .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2),
      .Use_Rs1(u1), .Use_Rs2(u2), .ID_EX_MemRead(mr), .ID_EX_Rd(rd),
      .EX_Redirect(redir), .PC_Stall(c_pcs), .IF_ID_Stall(c_ifs),
      .IF_ID_Flush(c_iff), .ID_EX_Flush(c_idf), .Hc_State(c_st),
      .Stall_Count(c_sc), .Flush_Count(c_fc)
   );

   // PC_Stall and IF_ID_Flush must never coincide in any instance
   always @(negedge clk) begin
      checks++;
      if ((a_pcs & a_iff) | (b_pcs & b_iff) | (c_pcs & c_iff)) begin
         errors++;
         $display("FAIL invariant pcs&iff a=%0b%0b b=%0b%0b c=%0b%0b exp no overlap",
                  a_pcs, a_iff, b_pcs, b_iff, c_pcs, c_iff);
      end
   end

   task automatic drive(input logic m, input logic [4:0] d,
                        input logic [4:0] s1, input logic e1,
                        input logic [4:0] s2, input logic e2,
                        input logic r);
      mr = m; rd = d; rs1 = s1; u1 = e1; rs2 = s2; u2 = e2; redir = r;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
      #2;
      checks++;
      if ({a_iff, a_idf, a_pcs, a_ifs} !== 4'b1100) begin
         errors++;
         $display("FAIL reset_ctl got %b exp 1100", {a_iff, a_idf, a_pcs, a_ifs});
      end
      tick;
      checks++;
      if (a_st !== 2'd0 || a_sc !== 32'd0 || a_fc !== 32'd0) begin
         errors++;
         $display("FAIL reset_regs got st=%0d sc=%0d fc=%0d exp 0 0 0", a_st, a_sc, a_fc);
      end
      rst = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick;
   endtask

   task automatic test_lu_one_bubble;
      do_reset;
      drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd9, 1'b0, 1'b0);
      #2;
      checks++;
      if ({a_pcs, a_ifs, a_idf, a_iff} !== 4'b1110 || a_st !== 2'd0) begin
         errors++;
         $display("FAIL lu1_stall got %b st=%0d exp 1110 st=0",
                  {a_pcs, a_ifs, a_idf, a_iff}, a_st);
      end
      tick;
      drive(1'b0, 5'd0, 5'd5, 1'b1, 5'd9, 1'b0, 1'b0);
      #2;
      checks++;
      if ({a_pcs, a_ifs, a_idf, a_iff} !== 4'b0000 || a_st !== 2'd0 || a_sc !== 32'd1) begin
         errors++;
         $display("FAIL lu1_after got %b st=%0d sc=%0d exp 0000 st=0 sc=1",
                  {a_pcs, a_ifs, a_idf, a_iff}, a_st, a_sc);
      end
   endtask

   task automatic test_lu_two_bubbles;
      do_reset;
      drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
      #2;
      checks++;
      if (b_pcs !== 1'b1 || b_st !== 2'd0) begin
         errors++;
         $display("FAIL lu2_c0 got pcs=%0b st=%0d exp 1 0", b_pcs, b_st);
      end
      tick;
      drive(1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
      #2;
      checks++;
      if ({b_pcs, b_ifs, b_idf} !== 3'b111 || b_st !== 2'd1) begin
         errors++;
         $display("FAIL lu2_c1 got %b st=%0d exp 111 st=1", {b_pcs, b_ifs, b_idf}, b_st);
      end
      tick;
      #2;
      checks++;
      if (b_pcs !== 1'b0 || b_st !== 2'd0 || b_sc !== 32'd2) begin
         errors++;
         $display("FAIL lu2_end got pcs=%0b st=%0d sc=%0d exp 0 0 2", b_pcs, b_st, b_sc);
      end
   endtask

   task automatic test_no_hazard;
      do_reset;
      drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
      #2;
      checks++;
      if ({a_pcs, a_ifs, a_idf, a_iff} !== 4'b0000) begin
         errors++;
         $display("FAIL nohaz_x0 got %b exp 0000", {a_pcs, a_ifs, a_idf, a_iff});
      end
      drive(1'b1, 5'd7, 5'd7, 1'b0, 5'd8, 1'b1, 1'b0);
      #2;
      checks++;
      if ({c_pcs, c_ifs, c_idf, c_iff} !== 4'b0000) begin
         errors++;
         $display("FAIL nohaz_unused got %b exp 0000", {c_pcs, c_ifs, c_idf, c_iff});
      end
      drive(1'b1, 5'd8, 5'd7, 1'b0, 5'd8, 1'b1, 1'b0);
      #2;
      checks++;
      if (c_pcs !== 1'b1) begin
         errors++;
         $display("FAIL haz_rs2 got pcs=%0b exp 1", c_pcs);
      end
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick;
      checks++;
      if (c_sc !== 32'd0 || c_st !== 2'd0) begin
         errors++;
         $display("FAIL nohaz_regs got sc=%0d st=%0d exp 0 0", c_sc, c_st);
      end
   endtask

   task automatic test_redirect_over_lu;
      do_reset;
      drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
      #2;
      checks++;
      if ({b_iff, b_idf, b_pcs, b_ifs} !== 4'b1100) begin
         errors++;
         $display("FAIL redir_c0 got %b exp 1100", {b_iff, b_idf, b_pcs, b_ifs});
      end
      tick;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #2;
      checks++;
      if ({b_iff, b_idf, b_pcs, b_ifs} !== 4'b1000 || b_st !== 2'd2) begin
         errors++;
         $display("FAIL redir_c1 got %b st=%0d exp 1000 st=2",
                  {b_iff, b_idf, b_pcs, b_ifs}, b_st);
      end
      tick;
      #2;
      checks++;
      if (b_iff !== 1'b0 || b_st !== 2'd0 || b_fc !== 32'd1 || b_sc !== 32'd0) begin
         errors++;
         $display("FAIL redir_end got iff=%0b st=%0d fc=%0d sc=%0d exp 0 0 1 0",
                  b_iff, b_st, b_fc, b_sc);
      end
   endtask

   task automatic test_back_to_back;
      do_reset;
      drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
      tick;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      #2;
      checks++;
      if ({c_iff, c_idf, c_pcs, c_ifs} !== 4'b1100 || c_st !== 2'd1) begin
         errors++;
         $display("FAIL b2b_abort got %b st=%0d exp 1100 st=1",
                  {c_iff, c_idf, c_pcs, c_ifs}, c_st);
      end
      tick;
      #2;
      checks++;
      if ({c_iff, c_idf} !== 2'b11 || c_st !== 2'd2 || c_fc !== 32'd1) begin
         errors++;
         $display("FAIL b2b_second got %b st=%0d fc=%0d exp 11 st=2 fc=1",
                  {c_iff, c_idf}, c_st, c_fc);
      end
      tick;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #2;
      checks++;
      if ({c_iff, c_idf} !== 2'b10 || c_st !== 2'd2 || c_fc !== 32'd2) begin
         errors++;
         $display("FAIL b2b_restart got %b st=%0d fc=%0d exp 10 st=2 fc=2",
                  {c_iff, c_idf}, c_st, c_fc);
      end
      tick;
      #2;
      checks++;
      if (c_st !== 2'd0 || c_fc !== 32'd2 || c_sc !== 32'd1 || c_iff !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end got st=%0d fc=%0d sc=%0d iff=%0b exp 0 2 1 0",
                  c_st, c_fc, c_sc, c_iff);
      end
   endtask

   task automatic test_reset_mid_redirect;
      do_reset;
      u_c.u_stall_cnt.cnt_q = 32'hFFFF_FFFF;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      tick;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #2;
      checks++;
      if (c_st !== 2'd2 || c_sc !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL rstmid_pre got st=%0d sc=%h exp 2 ffffffff", c_st, c_sc);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({c_iff, c_idf, c_pcs} !== 3'b110) begin
         errors++;
         $display("FAIL rstmid_ctl got %b exp 110", {c_iff, c_idf, c_pcs});
      end
      tick;
      rst = 1'b0;
      #1;
      checks++;
      if (c_st !== 2'd0 || c_sc !== 32'd0 || c_fc !== 32'd0 || c_iff !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_post got st=%0d sc=%0d fc=%0d iff=%0b exp 0 0 0 0",
                  c_st, c_sc, c_fc, c_iff);
      end
   endtask

   task automatic test_wrap;
      do_reset;
      u_a.u_stall_cnt.cnt_q = 32'hFFFF_FFFF;
      u_a.u_flush_cnt.cnt_q = 32'hFFFF_FFFF;
      drive(1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
      tick;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      #2;
      checks++;
      if (a_sc !== 32'd0) begin
         errors++;
         $display("FAIL wrap_stall got %h exp 00000000", a_sc);
      end
      tick;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #2;
      checks++;
      if (a_fc !== 32'd0 || a_st !== 2'd0) begin
         errors++;
         $display("FAIL wrap_flush got fc=%h st=%0d exp 00000000 0", a_fc, a_st);
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      test_reset;
      test_lu_one_bubble;
      test_lu_two_bubbles;
      test_no_hazard;
      test_redirect_over_lu;
      test_back_to_back;
      test_reset_mid_redirect;
      test_wrap;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Sequential hazard controller that generates the stall and flush controls consumed by the IF/ID and ID/EX pipeline registers and the PC register of the 5-stage RV32I core.
- Detects load-use hazards in ID against the load in EX, and inserts a configurable number of bubbles.
- On a taken branch or jump resolved in EX, squashes wrong-path instructions for a configurable number of cycles.
- Keeps wrap-around performance counters of stall cycles and redirect events.

Parameters:
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1..7); 2 for a registered-output data memory.
- FLUSH_CYCLES, 1, cycles IF/ID is flushed per redirect (1..7); 2 for a registered-output instruction memory.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- IF_ID_Rs1  in  5  rs1 field of the instruction in ID
- IF_ID_Rs2  in  5  rs2 field of the instruction in ID
- Use_Rs1  in  1  the ID instruction reads rs1
- Use_Rs2  in  1  the ID instruction reads rs2
- ID_EX_MemRead  in  1  the instruction in EX is a load
- ID_EX_Rd  in  5  destination register of the instruction in EX
- EX_Redirect  in  1  taken branch or jump resolved in EX this cycle
- PC_Stall  out  1  hold the PC
- IF_ID_Stall  out  1  hold IF/ID
- IF_ID_Flush  out  1  load NOP into IF/ID
- ID_EX_Flush  out  1  load NOP into ID/EX
- Hc_State  out  2  FSM state (0 RUN, 1 LU_STALL, 2 REDIRECT)
- Stall_Count  out  32  cycles with PC_Stall=1
- Flush_Count  out  32  accepted redirect events

Behaviour:
- Reset: while rst=1, the block forces IF_ID_Flush=1, ID_EX_Flush=1, PC_Stall=0 and IF_ID_Stall=0. On the reset edge, state goes to RUN, the bubble and flush counters clear, and Stall_Count and Flush_Count clear to 0. rst dominates every other input, including mid-stall and mid-redirect.
- Hazard term: lu = ID_EX_MemRead & (ID_EX_Rd!=0) & ((Use_Rs1 & IF_ID_Rs1==ID_EX_Rd) | (Use_Rs2 & IF_ID_Rs2==ID_EX_Rd)). x0 never creates a hazard.
- All outputs are combinational from the current state and inputs, so they take effect in the same cycle. Only the state, the counters and Stall_Count/Flush_Count are registered.
- Priority: rst > EX_Redirect > load-use.
- RUN state:
  - EX_Redirect=1: IF_ID_Flush=1, ID_EX_Flush=1, PC_Stall=0. The next state is REDIRECT with fcnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, otherwise RUN. lu is ignored this cycle.
  - Else lu=1: PC_Stall=1, IF_ID_Stall=1, ID_EX_Flush=1. The next state is LU_STALL with bcnt=LOAD_USE_BUBBLES-1 if LOAD_USE_BUBBLES>1, otherwise RUN.
  - Else: all controls are 0.
- LU_STALL state:
  - Asserts PC_Stall=1, IF_ID_Stall=1, ID_EX_Flush=1 without re-evaluating lu, because ID/EX now holds a NOP.
  - bcnt decrements each cycle; the state leaves for RUN in the cycle bcnt==1.
  - EX_Redirect=1 abandons the stall and is handled exactly as in RUN.
- REDIRECT state:
  - Asserts IF_ID_Flush=1 only; PC_Stall=0, IF_ID_Stall=0, ID_EX_Flush=0. fcnt decrements and the state returns to RUN in the cycle fcnt==1.
  - A new EX_Redirect=1 asserts both flushes, reloads fcnt=FLUSH_CYCLES-1 and counts as a new event.
  - lu is ignored in this state because the ID instruction is being squashed.
- Invariant: PC_Stall and IF_ID_Flush are never both 1.
- Counters:
  - Stall_Count += 1 on every clock with PC_Stall=1 and rst=0.
  - Flush_Count += 1 on every clock with an accepted EX_Redirect.
  - Both are modulo 2^32; 0xFFFFFFFF wraps to 0 with no flag.
- Hc_State value 3 is unreachable; if entered, the next state is RUN.

Decomposition:
- Shared package core_ctrl_pkg holds the state encoding constants (ST_RUN=0, ST_LU_STALL=1, ST_REDIRECT=2), REG_ZERO=5'd0, and the counter width constant PERF_W=32.
- One sub-module is natural: perf_counter (enable input, synchronous clear, PERF_W-wide wrap), instantiated twice.

Test Plan:
- Load-use on rs1 (ID_EX_MemRead=1, ID_EX_Rd=5, IF_ID_Rs1=5, Use_Rs1=1), LOAD_USE_BUBBLES=1 -> PC_Stall, IF_ID_Stall and ID_EX_Flush=1 for exactly 1 cycle; Stall_Count=1; Hc_State stays 0.
- Same hazard with LOAD_USE_BUBBLES=2 and ID_EX_MemRead dropped after the first cycle -> stall held 2 cycles; Hc_State goes 0,1,0; Stall_Count=2.
- Load with ID_EX_Rd=0 and IF_ID_Rs2=0, Use_Rs2=1; separately Use_Rs1=0 with a matching Rs1 -> no stall; all controls 0.
- EX_Redirect=1 together with lu=1 in RUN, FLUSH_CYCLES=2 -> cycle 0: both flushes 1, PC_Stall=0; cycle 1: IF_ID_Flush only; Flush_Count=1, Stall_Count=0.
- Redirect in the second cycle of LU_STALL (LOAD_USE_BUBBLES=3) -> the stall ends immediately and both flushes assert that cycle; a second redirect inside REDIRECT restarts fcnt; Flush_Count=2.
- Assert rst mid-REDIRECT with Stall_Count preloaded to 0xFFFFFFFF by a long stall -> both flushes 1 during reset; afterwards Hc_State=0 and both counters 0. A separate run without reset shows the wrap 0xFFFFFFFF->0.
